// File: rtl/snax_cgra_tcdm_port.sv
// Adapter between one CGRA en/rdy data-memory port and one TCDM request/response port.
// Requests are held in a one-entry slot; reads are credit-limited and their responses buffered in order.
module snax_cgra_tcdm_port #(
    parameter int unsigned              DataWidth     = 64,
    parameter int unsigned              TCDMAddrWidth = 48,
    parameter int unsigned              AddrWidth     = 6,
    parameter logic [TCDMAddrWidth-1:0] BaseAddr      = '0,
    parameter int unsigned              RspDepth      = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     waddr_en_i,
    input  logic [AddrWidth-1:0]     waddr_msg_i,
    output logic                     waddr_rdy_o,
    input  logic                     wdata_en_i,
    input  logic [17:0]              wdata_msg_i,
    output logic                     wdata_rdy_o,
    input  logic                     raddr_en_i,
    input  logic [AddrWidth-1:0]     raddr_msg_i,
    output logic                     raddr_rdy_o,
    output logic                     rdata_en_o,
    output logic [17:0]              rdata_msg_o,
    input  logic                     rdata_rdy_i,
    output logic                     tcdm_q_valid_o,
    input  logic                     tcdm_q_ready_i,
    output logic                     tcdm_q_write_o,
    output logic [TCDMAddrWidth-1:0] tcdm_q_addr_o,
    output logic [DataWidth-1:0]     tcdm_q_data_o,
    output logic [DataWidth/8-1:0]   tcdm_q_strb_o,
    input  logic                     tcdm_p_valid_i,
    input  logic [DataWidth-1:0]     tcdm_p_data_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ByteShift = $clog2(StrbWidth);
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RspDepth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RspDepth - 1);

    logic                     active;
    logic                     slot_full;
    logic                     slot_write;
    logic [TCDMAddrWidth-1:0] slot_addr;
    logic [DataWidth-1:0]     slot_data;
    logic [StrbWidth-1:0]     slot_strb;
    logic [CntWidth-1:0]      credits;
    logic [CntWidth-1:0]      outstanding;
    logic [CntWidth-1:0]      fifo_count;
    logic [PtrWidth-1:0]      rd_ptr;
    logic [PtrWidth-1:0]      wr_ptr;
    logic [15:0]              fifo_mem [RspDepth];
    logic                     err;

    logic slot_free;
    logic q_fire;
    logic rd_fire;
    logic wr_ready;
    logic wr_accept;
    logic wr_issue;
    logic wr_unpaired;
    logic rd_accept;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic rsp_take;
    logic push;
    logic unused_bits;

    function automatic logic [TCDMAddrWidth-1:0] map_addr(input logic [AddrWidth-1:0] msg);
        return BaseAddr + (TCDMAddrWidth'(msg) << ByteShift);
    endfunction

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    // The slot may be refilled in the same cycle it drains; writes take priority over reads.
    assign slot_free   = !slot_full || tcdm_q_ready_i;
    assign q_fire      = slot_full && tcdm_q_ready_i;
    assign rd_fire     = q_fire && !slot_write;
    assign wr_ready    = active && slot_free;
    assign wr_accept   = wr_ready && waddr_en_i && wdata_en_i;
    assign wr_issue    = wr_accept && wdata_msg_i[1];
    assign wr_unpaired = waddr_en_i ^ wdata_en_i;
    assign rd_accept   = raddr_en_i && raddr_rdy_o;

    assign fifo_empty  = (fifo_count == '0);
    assign fifo_full   = (fifo_count == DepthCnt);
    assign pop         = !fifo_empty && rdata_rdy_i;
    assign rsp_take    = tcdm_p_valid_i && (outstanding != '0);
    assign push        = rsp_take && !fifo_full;

    assign waddr_rdy_o    = wr_ready;
    assign wdata_rdy_o    = wr_ready;
    assign raddr_rdy_o    = wr_ready && (credits != '0) && !waddr_en_i;
    assign rdata_en_o     = pop;
    assign rdata_msg_o    = fifo_empty ? '0 : {fifo_mem[rd_ptr], 2'b10};
    assign tcdm_q_valid_o = slot_full;
    assign tcdm_q_write_o = slot_write;
    assign tcdm_q_addr_o  = slot_addr;
    assign tcdm_q_data_o  = slot_data;
    assign tcdm_q_strb_o  = slot_strb;
    assign busy_o         = slot_full || (outstanding != '0) || !fifo_empty;
    assign err_o          = err;

    assign unused_bits = ^{wdata_msg_i[0], tcdm_p_data_i[DataWidth-1:16]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active     <= 1'b0;
            slot_full  <= 1'b0;
            slot_write <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
            slot_strb  <= '0;
        end else begin
            active <= 1'b1;
            if (q_fire) begin
                slot_full <= 1'b0;
            end
            if (wr_issue) begin
                slot_full  <= 1'b1;
                slot_write <= 1'b1;
                slot_addr  <= map_addr(waddr_msg_i);
                slot_data  <= DataWidth'(wdata_msg_i[17:2]);
                slot_strb  <= '1;
            end else if (rd_accept) begin
                slot_full  <= 1'b1;
                slot_write <= 1'b0;
                slot_addr  <= map_addr(raddr_msg_i);
                slot_data  <= '0;
                slot_strb  <= '0;
            end
        end
    end

    // Credits are taken at read acceptance and returned when the tile pops the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits     <= DepthCnt;
            outstanding <= '0;
        end else begin
            case ({rd_accept, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   if (credits != DepthCnt) credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
            case ({rd_fire, rsp_take})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tcdm_p_data_i[15:0];
        end
    end

    // Unpaired write handshakes and responses nobody asked for are recorded until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (wr_unpaired || (tcdm_p_valid_i && !push)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/snax_cgra_tcdm_port.md
# snax_cgra_tcdm_port

Per-port adapter between one CGRA data-memory port (PyMTL en/rdy style) and one TCDM request/response port. It turns CGRA word addresses into TCDM byte addresses and holds each request stable until the TCDM accepts it. Reads are credit-limited, and their responses are buffered in order before they return to the tile. The CGRA wrapper instantiates one copy per memory-connected tile, in place of its inline combinational TCDM mapping.

## Interface
- DataWidth, 64, TCDM data width in bits (a multiple of 16).
- TCDMAddrWidth, 48, TCDM byte-address width.
- AddrWidth, 6, CGRA word-address width.
- BaseAddr, 0, TCDM byte base of this port's window.
- RspDepth, 2, response FIFO depth; also the read credit limit (≥1).
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- waddr_en_i  in  1  write address valid.
- waddr_msg_i  in  AddrWidth  write word address.
- waddr_rdy_o  out  1  write address ready.
- wdata_en_i  in  1  write data valid.
- wdata_msg_i  in  18  {payload[15:0], predicate, bypass}.
- wdata_rdy_o  out  1  write data ready; identical to waddr_rdy_o.
- raddr_en_i  in  1  read address valid.
- raddr_msg_i  in  AddrWidth  read word address.
- raddr_rdy_o  out  1  read address ready.
- rdata_en_o  out  1  read data valid.
- rdata_msg_o  out  18  {payload, predicate=1, bypass=0}.
- rdata_rdy_i  in  1  tile can take read data.
- tcdm_q_valid_o  out  1  TCDM request valid.
- tcdm_q_ready_i  in  1  TCDM request ready.
- tcdm_q_write_o  out  1  1 = write request.
- tcdm_q_addr_o  out  TCDMAddrWidth  request byte address.
- tcdm_q_data_o  out  DataWidth  write data.
- tcdm_q_strb_o  out  DataWidth/8  byte strobes.
- tcdm_p_valid_i  in  1  read response valid.
- tcdm_p_data_i  in  DataWidth  read response data.
- busy_o  out  1  work in flight; feeds the wrapper barrier.
- err_o  out  1  sticky protocol-error flag.

## Operation
- **Request slot (one entry)**
  - Holds {write, addr, data, strb} and drives the tcdm_q_* outputs directly.
  - tcdm_q_valid_o = slot_full.
  - The slot empties on tcdm_q_valid_o & tcdm_q_ready_i.
  - slot_free = !slot_full | tcdm_q_ready_i, so a new request may refill the slot in the same cycle it drains.
- **Address mapping:** addr = BaseAddr + (msg << log2(DataWidth/8)), truncated to TCDMAddrWidth.
- **Write acceptance**
  - waddr_rdy_o = wdata_rdy_o = slot_free.
  - A write is accepted only when waddr_en_i and wdata_en_i are both high in the same cycle.
  - On acceptance with predicate = 1:
    - the slot loads write = 1;
    - data = payload zero-extended to DataWidth;
    - strb = all ones.
  - On acceptance with predicate = 0: the write is consumed and dropped; no TCDM request is made.
  - If only one of waddr_en_i / wdata_en_i is high, nothing is accepted and err_o is set.
- **Read acceptance**
  - raddr_rdy_o = slot_free & (credits > 0) & !waddr_en_i. Writes win when both arrive in the same cycle.
  - On accept, the slot loads write = 0 and addr, with data and strb set to 0.
  - A credit is consumed at accept time.
- **Credits:** start at RspDepth. Decrement on read accept; increment on each rdata pop. Two's-complement net update when both happen in the same cycle. The credit count never underflows or overflows.
- **Response FIFO**
  - Pushes tcdm_p_data_i[15:0] on every tcdm_p_valid_i.
  - rdata_en_o = !empty & rdata_rdy_i; the FIFO pops in that cycle.
  - FIFO order equals TCDM response order, which is in order by TCDM contract.
  - A p_valid arriving when no read is outstanding (outstanding counter = 0) is dropped and sets err_o.
- **Outstanding counter:** +1 on a read handshake with the TCDM, −1 on p_valid.
- **busy_o** = slot_full | outstanding ≠ 0 | FIFO not empty.

## Timing
- **Reset values:** all outputs 0 except credits = RspDepth internally.
  - waddr_rdy_o / wdata_rdy_o / raddr_rdy_o go to 1 in the cycle after reset deasserts (they are combinational from the state).
  - Reset clears the slot, the FIFO, the counters and err_o.
  - Responses arriving after reset count as unexpected: they are dropped and set err_o.
- **Write:** accepted in cycle N; tcdm_q_valid_o is high from cycle N+1 until q_ready.
- **Read, best case:**
  - raddr accepted in cycle N.
  - q handshake in N+1.
  - p_valid in N+2 (TCDM latency 1), pushed into the FIFO at the end of N+2.
  - rdata_en_o in N+3.
- **Sustained throughput:** one request per cycle while tcdm_q_ready_i = 1 and credits remain.
- **Credit-exhausted boundary:** with RspDepth = 2, a third read is not accepted until a pop occurs.
- **Full FIFO cannot overflow:** the credit count bounds the FIFO count.
- **Request stability:** while tcdm_q_valid_o = 1 and tcdm_q_ready_i = 0, every tcdm_q_* output holds stable.

## Test plan
- **Address mapping:** BaseAddr = 0x100, write msg 5 with payload 0xBEEF, predicate 1, q_ready = 1.
  - Next cycle: q_valid = 1, write = 1, addr = 0x128, data = 0x…BEEF, strb = 0xFF.
- **Back-pressure:** hold q_ready = 0 for 4 cycles after a write.
  - q_* outputs stay stable; waddr_rdy_o = 0; the request is issued exactly once when q_ready rises.
- **Read latency:** read msg 3 with TCDM latency 1 returning 0x1234.
  - rdata_en_o in N+3 with payload 0x1234, predicate 1, bypass 0.
- **Credits:** rdata_rdy_i = 0, issue 3 reads.
  - The first two are accepted, raddr_rdy_o = 0 for the third; one pop frees a credit and the third is then accepted.
- **Simultaneous/drop cases:**
  - Write and read en in the same cycle: the write is issued first, then the read.
  - Predicate-0 write: consumed with no TCDM request.
  - waddr_en_i alone: err_o = 1.
- **Reset mid-read:** assert rst_i after the q handshake and before p_valid.
  - All outputs go to 0; the late p_valid is dropped and sets err_o; busy_o = 0.
